padd_strip: RTL

Inverse of the SHA-256 message padder. Accepts one padded 512-bit block, validates the padding (0x80 marker, zero fill, 64-bit big-endian bit-length field), and streams the original message bytes one per cycle over a valid/ready byte interface. Used as a loopback checker behind the padder and as the front end of the padded-block import path. Single-block messages only (0 to 55 bytes).

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/pad_check.sv | 43 ++++
 rtl/padd_strip.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 pad/strip datapath.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_STREAM,
    S_FIN,
    S_FAIL
  } strip_state_t;

  localparam int MAX_BYTES    = 55;
  localparam int LEN_LSB_BYTE = 56;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_MARK = 2'b10;
  localparam logic [1:0] ERR_FILL = 2'b11;

  // Byte k of a block, byte 0 in the most significant position.
  function automatic logic [7:0] get_byte(input logic [511:0] blk, input int k);
    return blk[511-8*k -: 8];
  endfunction

endpackage

// File: rtl/pad_check.sv
// Combinational validator for one padded SHA-256 block: returns {ok, err_code, n}.
module pad_check
  import sha256_pkg::*;
#(
  parameter int MAX_N = 55
) (
  input  logic [511:0] i_blk,
  output logic         o_ok,
  output logic [1:0]   o_err_code,
  output logic [5:0]   o_n
);

  logic [63:0] w_len;
  logic        w_len_ok;
  logic [5:0]  w_n;
  logic        w_mark_bad;
  logic        w_fill_bad;

  always_comb begin
    w_len      = i_blk[63:0];
    w_len_ok   = (w_len[2:0] == 3'b000) && (w_len[63:3] <= 61'(MAX_N));
    w_n        = w_len_ok ? w_len[8:3] : 6'd0;
    w_mark_bad = 1'b0;
    w_fill_bad = 1'b0;
    for (int k = 0; k < LEN_LSB_BYTE; k++) begin
      if (k == int'(w_n)) begin
        if (get_byte(i_blk, k) != 8'h80) w_mark_bad = 1'b1;
      end else if (k > int'(w_n)) begin
        if (get_byte(i_blk, k) != 8'h00) w_fill_bad = 1'b1;
      end
    end

    // Length is checked first: marker/fill positions are meaningless without it.
    if (!w_len_ok)       o_err_code = ERR_LEN;
    else if (w_mark_bad) o_err_code = ERR_MARK;
    else if (w_fill_bad) o_err_code = ERR_FILL;
    else                 o_err_code = ERR_NONE;

    o_ok = (o_err_code == ERR_NONE);
    o_n  = w_n;
  end

endmodule

// File: rtl/padd_strip.sv
// Strips SHA-256 padding from one 512-bit block and streams the message bytes.
module padd_strip
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic [511:0] blk_in,
  output logic         blk_ready,
  output logic [7:0]   data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         data_last,
  output logic [5:0]   msg_len,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code
);

  strip_state_t r_state, w_state_nxt;
  logic [511:0] r_blk;
  logic [5:0]   r_idx, w_idx_nxt;
  logic [5:0]   r_len, w_len_nxt;
  logic [7:0]   r_dout, w_dout_nxt;
  logic         r_dvalid, w_dvalid_nxt;
  logic         r_dlast, w_dlast_nxt;
  logic         r_done, w_done_nxt;
  logic         r_err, w_err_nxt;
  logic [1:0]   r_code, w_code_nxt;
  logic         r_blk_ready;
  logic         w_load_blk;

  logic         w_ok;
  logic [1:0]   w_chk_code;
  logic [5:0]   w_chk_n;
  logic [5:0]   w_idx_inc;

  pad_check #(.MAX_N(MAX_BYTES)) u_pad_check (
    .i_blk      (r_blk),
    .o_ok       (w_ok),
    .o_err_code (w_chk_code),
    .o_n        (w_chk_n)
  );

  assign w_idx_inc = r_idx + 6'd1;

  // Every output is a flop, so next-values are computed here and registered below.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_len_nxt    = r_len;
    w_dout_nxt   = r_dout;
    w_dvalid_nxt = r_dvalid;
    w_dlast_nxt  = r_dlast;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_code_nxt   = ERR_NONE;
    w_load_blk   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (blk_valid) begin
          w_load_blk  = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!w_ok) begin
          w_state_nxt = S_FAIL;
          w_err_nxt   = 1'b1;
          w_code_nxt  = w_chk_code;
        end else begin
          w_len_nxt = w_chk_n;
          w_idx_nxt = 6'd0;
          if (w_chk_n == 6'd0) begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt  = S_STREAM;
            w_dvalid_nxt = 1'b1;
            w_dout_nxt   = get_byte(r_blk, 0);
            w_dlast_nxt  = (w_chk_n == 6'd1);
          end
        end
      end
      S_STREAM: begin
        if (r_dvalid && data_ready) begin
          if (r_dlast) begin
            w_state_nxt  = S_FIN;
            w_done_nxt   = 1'b1;
            w_dvalid_nxt = 1'b0;
            w_dlast_nxt  = 1'b0;
            w_dout_nxt   = 8'h00;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_dout_nxt  = get_byte(r_blk, int'(w_idx_inc));
            w_dlast_nxt = (w_idx_inc == (r_len - 6'd1));
          end
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      S_FAIL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_blk       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_dout      <= '0;
      r_dvalid    <= 1'b0;
      r_dlast     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= ERR_NONE;
      r_blk_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      if (w_load_blk) r_blk <= blk_in;
      r_idx       <= w_idx_nxt;
      r_len       <= w_len_nxt;
      r_dout      <= w_dout_nxt;
      r_dvalid    <= w_dvalid_nxt;
      r_dlast     <= w_dlast_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_code      <= w_code_nxt;
      r_blk_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign blk_ready  = r_blk_ready;
  assign data_out   = r_dout;
  assign data_valid = r_dvalid;
  assign data_last  = r_dlast;
  assign msg_len    = r_len;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_code;

endmodule
